bc_poly: RTL and testbench



---
 rtl/bc_pkg.sv | 51 +++++
 rtl/bc_poly_rom.sv | 58 +++++
 rtl/bc_poly.sv | 90 +++++++++
 tb/tb_bc_poly.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bc_pkg.sv
// Shared definitions for the polynomial sequencer bc_poly.
//   - state_t : 3-bit FSM state encoding
//   - ctrl_t  : 11-bit control word driven to the datapath
//   - SEL0_*/SEL1_*/SEL2_* : operand mux select codes
//   - H_ADD_DEF/H_MUL_DEF  : default ALU function codes
package bc_pkg;

  localparam logic H_ADD_DEF = 1'b0;
  localparam logic H_MUL_DEF = 1'b1;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LDX  = 3'd1,
    MXX  = 3'd2,
    MAH  = 3'd3,
    MBX  = 3'd4,
    ASH  = 3'd5,
    ASC  = 3'd6,
    DONE = 3'd7
  } state_t;

  // mux0: constant operand source
  localparam logic [1:0] SEL0_ZERO = 2'b00;
  localparam logic [1:0] SEL0_A    = 2'b01;
  localparam logic [1:0] SEL0_B    = 2'b10;
  localparam logic [1:0] SEL0_C    = 2'b11;

  // mux1: second ALU operand
  localparam logic [1:0] SEL1_M0 = 2'b00;
  localparam logic [1:0] SEL1_RX = 2'b01;
  localparam logic [1:0] SEL1_RS = 2'b10;
  localparam logic [1:0] SEL1_RH = 2'b11;

  // mux2: first ALU operand
  localparam logic [1:0] SEL2_RX = 2'b00;
  localparam logic [1:0] SEL2_M0 = 2'b01;
  localparam logic [1:0] SEL2_RS = 2'b10;
  localparam logic [1:0] SEL2_RH = 2'b11;

  typedef struct packed {
    logic       lx;
    logic       ls;
    logic       lh;
    logic       h;
    logic [1:0] m0;
    logic [1:0] m1;
    logic [1:0] m2;
    logic       done;
  } ctrl_t;

endpackage

// File: rtl/bc_poly_rom.sv
// Combinational state-to-control-word decode for bc_poly.
//   state : current FSM state
//   ctrl  : {LX, LS, LH, H, M0, M1, M2, done}
// ALU operand order is (mux2, mux1); each step below names its result.
module bc_poly_rom
  import bc_pkg::*;
#(
  parameter logic H_ADD = H_ADD_DEF,
  parameter logic H_MUL = H_MUL_DEF
) (
  input  state_t state,
  output ctrl_t  ctrl
);

  always_comb begin
    ctrl   = '0;
    ctrl.h = H_ADD;
    case (state)
      LDX: ctrl.lx = 1'b1;
      MXX: begin                      // RH <= X*X
        ctrl.m2 = SEL2_RX;
        ctrl.m1 = SEL1_RX;
        ctrl.h  = H_MUL;
        ctrl.lh = 1'b1;
      end
      MAH: begin                      // RH <= A*RH
        ctrl.m0 = SEL0_A;
        ctrl.m2 = SEL2_M0;
        ctrl.m1 = SEL1_RH;
        ctrl.h  = H_MUL;
        ctrl.lh = 1'b1;
      end
      MBX: begin                      // RS <= B*X
        ctrl.m0 = SEL0_B;
        ctrl.m2 = SEL2_M0;
        ctrl.m1 = SEL1_RX;
        ctrl.h  = H_MUL;
        ctrl.ls = 1'b1;
      end
      ASH: begin                      // RS <= RS+RH
        ctrl.m2 = SEL2_RS;
        ctrl.m1 = SEL1_RH;
        ctrl.h  = H_ADD;
        ctrl.ls = 1'b1;
      end
      ASC: begin                      // RS <= C+RS
        ctrl.m0 = SEL0_C;
        ctrl.m2 = SEL2_M0;
        ctrl.m1 = SEL1_RS;
        ctrl.h  = H_ADD;
        ctrl.ls = 1'b1;
      end
      DONE: ctrl.done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/bc_poly.sv
// Sequencer for Resultado = A*X^2 + B*X + C on the X/S/H datapath.
//   clk, rst_n         : clock, async active-low reset
//   start              : request an evaluation (sampled in IDLE only)
//   ovf_in             : datapath overflow for the current ALU operands
//   LX, LS, LH         : register load enables
//   H                  : ALU function select
//   M0, M1, M2         : operand mux selects
//   busy, done, err    : status; err is sticky per evaluation
//
// state | meaning
// IDLE  | waiting for start
// LDX   | capture X
// MXX   | RH <= X*X
// MAH   | RH <= A*RH
// MBX   | RS <= B*X
// ASH   | RS <= RS+RH
// ASC   | RS <= RS+C
// DONE  | result valid, one cycle
module bc_poly
  import bc_pkg::*;
#(
  parameter logic H_ADD = H_ADD_DEF,
  parameter logic H_MUL = H_MUL_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       ovf_in,
  output logic       LX,
  output logic       LS,
  output logic       LH,
  output logic       H,
  output logic [1:0] M0,
  output logic [1:0] M1,
  output logic [1:0] M2,
  output logic       busy,
  output logic       done,
  output logic       err
);

  state_t state, state_nxt;
  ctrl_t  ctrl;
  logic   arith_state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = IDLE;
    case (state)
      IDLE:    state_nxt = start ? LDX : IDLE;
      LDX:     state_nxt = MXX;
      MXX:     state_nxt = MAH;
      MAH:     state_nxt = MBX;
      MBX:     state_nxt = ASH;
      ASH:     state_nxt = ASC;
      ASC:     state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ovf_in is only meaningful while the ALU result is being loaded.
  assign arith_state = (state == MXX) || (state == MAH) || (state == MBX) ||
                       (state == ASH) || (state == ASC);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     err <= 1'b0;
    else if (state == IDLE && start) err <= 1'b0;
    else if (arith_state)           err <= err | ovf_in;
  end

  bc_poly_rom #(.H_ADD(H_ADD), .H_MUL(H_MUL)) u_rom (
    .state (state),
    .ctrl  (ctrl)
  );

  assign LX   = ctrl.lx;
  assign LS   = ctrl.ls;
  assign LH   = ctrl.lh;
  assign H    = ctrl.h;
  assign M0   = ctrl.m0;
  assign M1   = ctrl.m1;
  assign M2   = ctrl.m2;
  assign done = ctrl.done;
  assign busy = (state != IDLE);

endmodule

// File: tb/tb_bc_poly.sv
module tb_bc_poly;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        ovf_in;
  logic        LX, LS, LH, H, busy, done, err;
  logic [1:0]  M0, M1, M2;
  logic [15:0] x = '0, a = '0, b = '0, c = '0;

  int n_tests = 0;
  int n_fail  = 0;

  logic [10:0] cw [0:19];
  int          cw_n;

  always #5 clk = ~clk;

  bc_poly dut (
    .clk(clk), .rst_n(rst_n), .start(start), .ovf_in(ovf_in),
    .LX(LX), .LS(LS), .LH(LH), .H(H), .M0(M0), .M1(M1), .M2(M2),
    .busy(busy), .done(done), .err(err)
  );

  // Behavioural datapath driven by the controller.
  logic [15:0] rx, rs, rh, m0o, m1o, m2o;
  logic [31:0] alu;

  always_comb begin
    m0o = '0;
    case (M0)
      2'b01: m0o = a;
      2'b10: m0o = b;
      2'b11: m0o = c;
      default: m0o = '0;
    endcase
    case (M1)
      2'b00: m1o = m0o;
      2'b01: m1o = rx;
      2'b10: m1o = rs;
      default: m1o = rh;
    endcase
    case (M2)
      2'b00: m2o = rx;
      2'b01: m2o = m0o;
      2'b10: m2o = rs;
      default: m2o = rh;
    endcase
    alu    = H ? (32'(m2o) * 32'(m1o)) : (32'(m2o) + 32'(m1o));
    ovf_in = |alu[31:16];
  end

  always @(posedge clk) begin
    if (LX) rx <= x;
    if (LS) rs <= alu[15:0];
    if (LH) rh <= alu[15:0];
  end

  // Reference: the polynomial in wrap-around 16-bit arithmetic, flagging
  // any intermediate product or sum that does not fit in 16 bits.
  function automatic void model(input logic [15:0] xi, ai, bi, ci,
                                output logic [15:0] r, output logic e);
    logic [31:0] xx, axx, bxv, s1, s2;
    xx  = 32'(xi) * 32'(xi);
    axx = 32'(ai) * 32'(xx[15:0]);
    bxv = 32'(bi) * 32'(xi);
    s1  = 32'(bxv[15:0]) + 32'(axx[15:0]);
    s2  = 32'(s1[15:0]) + 32'(ci);
    e = (xx > 32'hFFFF) || (axx > 32'hFFFF) || (bxv > 32'hFFFF) ||
        (s1 > 32'hFFFF) || (s2 > 32'hFFFF);
    r = s2[15:0];
  endfunction

  // Pulse start once and follow the run to done (bounded at 20 cycles).
  task automatic run_eval(input logic [15:0] xi, ai, bi, ci,
                          output int lat, output int bcnt);
    @(negedge clk);
    x = xi; a = ai; b = bi; c = ci;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1; bcnt = 0; cw_n = 0;
    while (lat < 20) begin
      if (busy) bcnt++;
      if (cw_n < 20) begin
        cw[cw_n] = {LX, LS, LH, H, M0, M1, M2, done};
        cw_n++;
      end
      if (done) break;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #23;
    n_tests++;
    if ({LX, LS, LH, H, M0, M1, M2, busy, done, err} !== 13'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b want 0",
               {LX, LS, LH, H, M0, M1, M2, busy, done, err});
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle_hold: busy=%b want 0", busy);
    end
  endtask

  task automatic test_nominal;
    int lat, bcnt;
    run_eval(16'd3, 16'd2, 16'd4, 16'd5, lat, bcnt);
    n_tests++;
    if (lat !== 7) begin
      n_fail++;
      $display("FAIL nominal_latency: got %0d want 7", lat);
    end
    n_tests++;
    if (bcnt !== 7) begin
      n_fail++;
      $display("FAIL nominal_busy_cycles: got %0d want 7", bcnt);
    end
    n_tests++;
    if (rs !== 16'h0023 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL nominal_result: got %h err=%b want 0023 err=0", rs, err);
    end
    @(negedge clk);
    n_tests++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL nominal_done_pulse: done=%b busy=%b want 0 0", done, busy);
    end
  endtask

  task automatic test_zero;
    int lat, bcnt;
    logic [10:0] exp_cw [0:6];
    exp_cw[0] = 11'b1000_00_00_00_0;  // LDX
    exp_cw[1] = 11'b0011_00_01_00_0;  // MXX
    exp_cw[2] = 11'b0011_01_11_01_0;  // MAH
    exp_cw[3] = 11'b0101_10_01_01_0;  // MBX
    exp_cw[4] = 11'b0100_00_11_10_0;  // ASH
    exp_cw[5] = 11'b0100_11_10_01_0;  // ASC
    exp_cw[6] = 11'b0000_00_00_00_1;  // DONE
    run_eval(16'd0, 16'd7, 16'd9, 16'h1234, lat, bcnt);
    n_tests++;
    if (rs !== 16'h1234 || lat !== 7) begin
      n_fail++;
      $display("FAIL zero_result: got %h lat=%0d want 1234 lat=7", rs, lat);
    end
    for (int i = 0; i < 7; i++) begin
      n_tests++;
      if (i >= cw_n || cw[i] !== exp_cw[i]) begin
        n_fail++;
        $display("FAIL zero_ctrl_word[%0d]: got %b want %b", i, cw[i], exp_cw[i]);
      end
    end
  endtask

  task automatic test_overflow;
    int lat, bcnt;
    run_eval(16'd4, 16'h4000, 16'd0, 16'd0, lat, bcnt);
    n_tests++;
    if (err !== 1'b1 || lat !== 7) begin
      n_fail++;
      $display("FAIL ovf_err_at_done: err=%b lat=%0d want 1 7", err, lat);
    end
    repeat (3) @(negedge clk);
    n_tests++;
    if (err !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_err_held_idle: err=%b busy=%b want 1 0", err, busy);
    end
    run_eval(16'd1, 16'd1, 16'd1, 16'd1, lat, bcnt);
    n_tests++;
    if (err !== 1'b0 || rs !== 16'd3) begin
      n_fail++;
      $display("FAIL ovf_clear_next: err=%b res=%0d want 0 3", err, rs);
    end
  endtask

  task automatic test_busy_ignore;
    int ndone = 0;
    @(negedge clk);
    x = 16'd3; a = 16'd2; b = 16'd4; c = 16'd5;
    start = 1'b1;
    for (int n = 1; n <= 18; n++) begin
      @(negedge clk);
      if (done) ndone++;
      start = (n == 3) || (n == 7);   // MAH and DONE cycles
    end
    start = 1'b0;
    n_tests++;
    if (ndone !== 1) begin
      n_fail++;
      $display("FAIL busy_ignore_done_count: got %0d want 1", ndone);
    end
    n_tests++;
    if (busy !== 1'b0 || rs !== 16'd35) begin
      n_fail++;
      $display("FAIL busy_ignore_idle: busy=%b res=%0d want 0 35", busy, rs);
    end
  endtask

  task automatic test_reset_mid;
    int lat, bcnt;
    @(negedge clk);
    x = 16'd4; a = 16'h4000; b = 16'd0; c = 16'd0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);        // now in MBX
    n_tests++;
    if (LS !== 1'b1 || err !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid_in_mbx: LS=%b err=%b want 1 1", LS, err);
    end
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({LX, LS, LH, H, M0, M1, M2, busy, done, err} !== 13'b0) begin
      n_fail++;
      $display("FAIL rstmid_async: got %b want 0",
               {LX, LS, LH, H, M0, M1, M2, busy, done, err});
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_eval(16'd2, 16'd1, 16'd1, 16'd1, lat, bcnt);
    n_tests++;
    if (rs !== 16'd7 || lat !== 7 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_rerun: res=%0d lat=%0d err=%b want 7 7 0", rs, lat, err);
    end
  endtask

  task automatic test_back_to_back;
    int dq[$];
    int w;
    @(negedge clk);
    x = 16'd3; a = 16'd2; b = 16'd4; c = 16'd5;
    start = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (done) dq.push_back(n);
    end
    start = 1'b0;
    n_tests++;
    if (dq.size() != 2 || dq[0] != 7 || dq[1] != 15) begin
      n_fail++;
      $display("FAIL held_start_done_cycles: got %p want 7 15", dq);
    end
    w = 0;
    while (busy && w < 20) begin
      @(negedge clk);
      w++;
    end
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL held_start_settle: busy=%b want 0", busy);
    end
  endtask

  task automatic test_random;
    int lat, bcnt;
    logic [15:0] xi, ai, bi, ci, er;
    logic ee;
    for (int i = 0; i < 24; i++) begin
      if (i[0]) begin
        xi = 16'($urandom); ai = 16'($urandom);
        bi = 16'($urandom); ci = 16'($urandom);
      end else begin
        xi = 16'($urandom_range(0, 40)); ai = 16'($urandom_range(0, 30));
        bi = 16'($urandom_range(0, 300)); ci = 16'($urandom);
      end
      model(xi, ai, bi, ci, er, ee);
      run_eval(xi, ai, bi, ci, lat, bcnt);
      n_tests++;
      if (rs !== er || err !== ee || lat !== 7) begin
        n_fail++;
        $display("FAIL random[%0d] x=%h a=%h b=%h c=%h: res=%h err=%b lat=%0d want %h %b 7",
                 i, xi, ai, bi, ci, rs, err, lat, er, ee);
      end
      repeat ($urandom_range(1, 3)) @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_zero();
    test_overflow();
    test_busy_ignore();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
